// File: rtl/alu4_issue.sv
// Command issue stage for the 4-bit ALU: buffers commands in a FIFO and drives one at a time.
// Optional macro ALU4_ISSUE_BYPASS_EN loads a command straight into the ALU registers when idle.
module alu4_issue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_a,
    input  logic [3:0]    cmd_b,
    input  logic [2:0]    cmd_op,
    input  logic          cmd_cin,
    output logic [3:0]    alu_a,
    output logic [3:0]    alu_b,
    output logic [2:0]    alu_c,
    output logic          alu_cin,
    input  logic [3:0]    alu_result,
    input  logic          alu_zero,
    input  logic          alu_overflow,
    input  logic          alu_carry,
    input  logic          alu_size,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [3:0]    rsp_result,
    output logic [3:0]    rsp_flags,
    output logic [2:0]    rsp_op,
    output logic          busy,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic       cin;
    } cmd_t;

    state_e        state_q, state_d;
    cmd_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic  full, empty;
    logic  push, pop, bypass;
    logic  load_alu, capture, rsp_clear;
    cmd_t  cmd_in, load_cmd;
    logic [3:0] flags_masked;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign cmd_in    = '{a: cmd_a, b: cmd_b, op: cmd_op, cin: cmd_cin};

`ifdef ALU4_ISSUE_BYPASS_EN
    assign bypass = (state_q == StIdle) && empty && cmd_valid;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed command goes straight to the ALU registers and never occupies a FIFO slot.
    assign push     = cmd_valid && cmd_ready && !bypass;
    assign load_cmd = bypass ? cmd_in : mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        load_alu  = 1'b0;
        capture   = 1'b0;
        rsp_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop      = 1'b1;
                    load_alu = 1'b1;
                    state_d  = StDrive;
                end else if (bypass) begin
                    load_alu = 1'b1;
                    state_d  = StDrive;
                end
            end
            StDrive: begin
                capture = 1'b1;
                state_d = StHold;
            end
            StHold: begin
                if (rsp_ready) begin
                    rsp_clear = 1'b1;
                    if (!empty) begin
                        pop      = 1'b1;
                        load_alu = 1'b1;
                        state_d  = StDrive;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Only flags the ALU defines for the opcode are passed through.
    always_comb begin
        flags_masked = 4'b0000;
        unique case (alu_c)
            3'b000, 3'b001: flags_masked = {1'b0, alu_overflow, alu_carry, 1'b0};
            3'b110, 3'b111: flags_masked = {alu_zero, alu_overflow, alu_carry, alu_size};
            default:        flags_masked = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_c      <= '0;
            alu_cin    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_op     <= '0;
        end else begin
            state_q <= state_d;
            if (load_alu) begin
                alu_a   <= load_cmd.a;
                alu_b   <= load_cmd.b;
                alu_c   <= load_cmd.op;
                alu_cin <= load_cmd.cin;
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_flags  <= flags_masked;
                rsp_op     <= alu_c;
                rsp_valid  <= 1'b1;
            end else if (rsp_clear) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign busy  = (state_q != StIdle) || !empty;
    assign count = count_q;

endmodule

// File: tb/tb_alu4_issue.sv
// Directed self-checking bench for alu4_issue with a stub ALU driven by the bench.
module tb_alu4_issue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef ALU4_ISSUE_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [3:0]    cmd_a, cmd_b;
    logic [2:0]    cmd_op;
    logic          cmd_cin;
    logic [3:0]    alu_a, alu_b;
    logic [2:0]    alu_c;
    logic          alu_cin;
    logic [3:0]    alu_result;
    logic          alu_zero, alu_overflow, alu_carry, alu_size;
    logic          rsp_valid, rsp_ready;
    logic [3:0]    rsp_result, rsp_flags;
    logic [2:0]    rsp_op;
    logic          busy;
    logic [CW-1:0] count;

    logic       stub_echo;
    logic [3:0] stub_result;

    int compared   = 0;
    int mismatched = 0;
    int accepted;

    // Stub ALU: either a fixed result or an echo of operand a to tag ordering.
    assign alu_result = stub_echo ? alu_a : stub_result;

    always #5 clk = ~clk;

    alu4_issue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_op       (cmd_op),
        .cmd_cin      (cmd_cin),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_c        (alu_c),
        .alu_cin      (alu_cin),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .alu_carry    (alu_carry),
        .alu_size     (alu_size),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_op       (rsp_op),
        .busy         (busy),
        .count        (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input string tag, input logic [3:0] a, input logic [3:0] b,
                              input logic [2:0] op, input logic cin, input logic [3:0] res,
                              input logic z, input logic o, input logic c, input logic s,
                              input logic [3:0] exp_flags);
        stub_echo    = 1'b0;
        stub_result  = res;
        alu_zero     = z;
        alu_overflow = o;
        alu_carry    = c;
        alu_size     = s;
        rsp_ready    = 1'b0;
        cmd_a        = a;
        cmd_b        = b;
        cmd_op       = op;
        cmd_cin      = cin;
        cmd_valid    = 1'b1;
        check({tag, ".rdy"}, 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check({tag, ".cnt1"}, 32'(count), (LAT == 2) ? 32'd0 : 32'd1);
        check({tag, ".v1"}, 32'(rsp_valid), 32'd0);
        if (LAT == 3) tick();
        check({tag, ".alu"}, {19'd0, alu_a, alu_b, alu_c, alu_cin}, {19'd0, a, b, op, cin});
        check({tag, ".v2"}, 32'(rsp_valid), 32'd0);
        tick();
        check({tag, ".vld"}, 32'(rsp_valid), 32'd1);
        check({tag, ".res"}, 32'(rsp_result), 32'(res));
        check({tag, ".flg"}, 32'(rsp_flags), 32'(exp_flags));
        check({tag, ".op"}, 32'(rsp_op), 32'(op));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, ".done"}, 32'(rsp_valid), 32'd0);
        check({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_a        = '0;
        cmd_b        = '0;
        cmd_op       = '0;
        cmd_cin      = 1'b0;
        rsp_ready    = 1'b0;
        stub_echo    = 1'b0;
        stub_result  = '0;
        alu_zero     = 1'b0;
        alu_overflow = 1'b0;
        alu_carry    = 1'b0;
        alu_size     = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst.rdy", 32'(cmd_ready), 32'd1);
        check("rst.vld", 32'(rsp_valid), 32'd0);
        check("rst.cnt", 32'(count), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.alu", {20'd0, alu_a, alu_b, alu_c, alu_cin}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // a, b, op, cin, stub result, z, o, c, s, expected masked flags
        run_single("add",  4'h7, 4'h1, 3'b000, 1'b0, 4'h8, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0100);
        run_single("sub",  4'h3, 4'h5, 3'b001, 1'b1, 4'hE, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010);
        run_single("log2", 4'h0, 4'h0, 3'b010, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);
        run_single("log3", 4'h5, 4'h6, 3'b011, 1'b0, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);
        run_single("log5", 4'hA, 4'h5, 3'b101, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);
        run_single("cmp6", 4'h2, 4'h4, 3'b110, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
        run_single("cmp7", 4'hF, 4'hF, 3'b111, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);

        // Backpressure: 8 offered commands, only in-flight + DEPTH fit.
        stub_echo    = 1'b1;
        alu_zero     = 1'b0;
        alu_overflow = 1'b0;
        alu_carry    = 1'b0;
        alu_size     = 1'b0;
        rsp_ready    = 1'b0;
        cmd_op       = 3'b000;
        cmd_b        = 4'h0;
        cmd_cin      = 1'b0;
        accepted     = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_a     = 4'(i + 1);
            cmd_valid = 1'b1;
            #1;
            if (cmd_ready) accepted++;
            tick();
        end
        cmd_valid = 1'b0;
        check("bp.acc", 32'(accepted), 32'd5);
        check("bp.cnt", 32'(count), 32'd4);
        check("bp.rdy", 32'(cmd_ready), 32'd0);
        check("bp.vld", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("bp.v%0d", k), 32'(rsp_valid), 32'd1);
            check($sformatf("bp.r%0d", k), 32'(rsp_result), 32'(k));
            tick();
            check($sformatf("bp.gap%0d", k), 32'(rsp_valid), 32'd0);
            check($sformatf("bp.c%0d", k), 32'(count), (k < 4) ? 32'(4 - k) : 32'd0);
            if (k < 5) tick();
        end
        rsp_ready = 1'b0;
        check("bp.idle", 32'(busy), 32'd0);
        check("bp.rdy2", 32'(cmd_ready), 32'd1);

        // Reset while holding a response with two commands queued.
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_a = 4'(9 + i);
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        check("mr.cnt", 32'(count), 32'd2);
        check("mr.vld", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mr.rvld", 32'(rsp_valid), 32'd0);
        check("mr.rcnt", 32'(count), 32'd0);
        check("mr.ralu", {20'd0, alu_a, alu_b, alu_c, alu_cin}, 32'd0);
        check("mr.rrdy", 32'(cmd_ready), 32'd1);
        check("mr.rres", 32'(rsp_result), 32'd0);
        check("mr.rbusy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("mr.idle", 32'(busy), 32'd0);
        check("mr.vld2", 32'(rsp_valid), 32'd0);
        run_single("post", 4'h6, 4'h2, 3'b000, 1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
